// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with IMM-prefix support.
// One pipeline stage, valid/ready on both sides, flush for redirects.
module imm_gen_pipe #(
    parameter int DATA_W    = 16,
    parameter bit PREFIX_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instruction,
    input  logic [2:0]        ImmSrc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic              imm_prefixed
);

    typedef enum logic [2:0] {
        M_ZX8   = 3'b000,
        M_SX6   = 3'b001,
        M_SHAMT = 3'b010,
        M_PFX   = 3'b011,
        M_SX8   = 3'b100,
        M_RSV5  = 3'b101,
        M_RSV6  = 3'b110,
        M_RSV7  = 3'b111
    } imm_mode_e;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              pfx_used_q, pfx_used_d;
    logic              prefix_pend_q, prefix_pend_d;
    logic [11:0]       prefix_reg_q, prefix_reg_d;

    imm_mode_e         mode;
    logic              accept;
    logic              is_prefix;
    logic              ext_pfx;
    logic              unused_hi;

    assign unused_hi = ^instruction[15:12];

    // Builds a 32-bit candidate; the caller keeps the low DATA_W bits.
    function automatic logic [31:0] build_imm(
        input imm_mode_e   m,
        input logic [15:0] ins,
        input logic        pend,
        input logic [11:0] preg
    );
        logic [7:0]  f8;
        logic [5:0]  f6;
        logic [31:0] r;
        f8 = ins[11:4];
        f6 = ins[5:0];
        r  = '0;
        case (m)
            M_ZX8: begin
                if (pend) r = {12'b0, preg, f8};
                else      r = {24'b0, f8};
            end
            M_SX8: begin
                if (pend) r = {{12{preg[11]}}, preg, f8};
                else      r = {{24{f8[7]}}, f8};
            end
            M_SX6: begin
                if (pend) r = {{14{preg[11]}}, preg, f6};
                else      r = {{26{f6[5]}}, f6};
            end
            M_SHAMT: r = {29'b0, ins[5:3]};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign mode      = imm_mode_e'(ImmSrc);
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign is_prefix = PREFIX_EN && (mode == M_PFX);

    always_comb begin
        ext_pfx = 1'b0;
        case (mode)
            M_ZX8, M_SX8, M_SX6: ext_pfx = prefix_pend_q;
            default:             ext_pfx = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        imm_d         = imm_q;
        pfx_used_d    = pfx_used_q;
        prefix_pend_d = prefix_pend_q;
        prefix_reg_d  = prefix_reg_q;

        if (out_ready) out_valid_d = 1'b0;

        if (accept && is_prefix) begin
            prefix_reg_d  = instruction[11:0];
            prefix_pend_d = 1'b1;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            imm_d         = DATA_W'(build_imm(mode, instruction,
                                              prefix_pend_q,
                                              prefix_reg_q));
            pfx_used_d    = ext_pfx;
            prefix_pend_d = 1'b0;
        end

        // A redirect kills both the output beat and any pending prefix.
        if (flush) begin
            out_valid_d   = 1'b0;
            imm_d         = imm_q;
            pfx_used_d    = 1'b0;
            prefix_pend_d = 1'b0;
            prefix_reg_d  = prefix_reg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            imm_q         <= '0;
            pfx_used_q    <= 1'b0;
            prefix_pend_q <= 1'b0;
            prefix_reg_q  <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            imm_q         <= imm_d;
            pfx_used_q    <= pfx_used_d;
            prefix_pend_q <= prefix_pend_d;
            prefix_reg_q  <= prefix_reg_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign imm_out      = imm_q;
    assign imm_prefixed = pfx_used_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed literals plus random stimulus
// checked every cycle against an arithmetic reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] instruction = '0;
    logic [2:0]  ImmSrc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, imm_prefixed;
    logic [15:0] imm_out;
    logic        np_in_ready, np_out_valid, np_prefixed;
    logic [15:0] np_imm;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    imm_gen_pipe #(.DATA_W(16), .PREFIX_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready), .instruction(instruction),
        .ImmSrc(ImmSrc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .imm_out(imm_out),
        .imm_prefixed(imm_prefixed)
    );

    imm_gen_pipe #(.DATA_W(16), .PREFIX_EN(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(np_in_ready), .instruction(instruction),
        .ImmSrc(ImmSrc), .flush(flush), .out_valid(np_out_valid),
        .out_ready(out_ready), .imm_out(np_imm),
        .imm_prefixed(np_prefixed)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_valid, m_pf, m_pend;
    logic [15:0] m_imm;
    int          m_preg;

    function automatic void mexp(input int ins, input int md,
                                 input bit pend, input int preg,
                                 output logic [15:0] imm,
                                 output bit pf);
        int v;
        int f8;
        int f6;
        f8 = (ins >> 4) & 255;
        f6 = ins & 63;
        v  = 0;
        pf = 1'b0;
        case (md)
            0: begin
                v  = pend ? preg * 256 + f8 : f8;
                pf = pend;
            end
            4: begin
                if (pend) begin
                    v = preg * 256 + f8;
                    if (v >= (1 << 19)) v -= (1 << 20);
                    pf = 1'b1;
                end else begin
                    v = f8;
                    if (v >= 128) v -= 256;
                end
            end
            1: begin
                if (pend) begin
                    v = preg * 64 + f6;
                    if (v >= (1 << 17)) v -= (1 << 18);
                    pf = 1'b1;
                end else begin
                    v = f6;
                    if (v >= 32) v -= 64;
                end
            end
            2: v = (ins >> 3) & 7;
            default: v = 0;
        endcase
        imm = v[15:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit          acc;
        logic [15:0] e;
        bit          p;
        if (!rst_n) begin
            m_valid = 0; m_pf = 0; m_pend = 0;
            m_imm = '0; m_preg = 0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (out_ready) m_valid = 0;
            if (flush) begin
                m_valid = 0; m_pf = 0; m_pend = 0;
            end else if (acc && ImmSrc == 3'b011) begin
                m_preg = int'(instruction) & 12'hFFF;
                m_pend = 1;
            end else if (acc) begin
                mexp(int'(instruction), int'(ImmSrc), m_pend,
                     m_preg, e, p);
                m_imm = e; m_pf = p; m_valid = 1; m_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL model_valid got=%0b exp=%0b t=%0t",
                         out_valid, m_valid, $time);
            end
            checks++;
            if (in_ready !== (!m_valid || out_ready)) begin
                errors++;
                $display("FAIL model_ready got=%0b exp=%0b t=%0t",
                         in_ready, !m_valid || out_ready, $time);
            end
            if (m_valid) begin
                checks++;
                if (imm_out !== m_imm || imm_prefixed !== m_pf) begin
                    errors++;
                    $display("FAIL model_imm got=%h/%0b exp=%h/%0b t=%0t",
                             imm_out, imm_prefixed, m_imm, m_pf, $time);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic [2:0] md);
        in_valid    = 1'b1;
        instruction = ins;
        ImmSrc      = md;
    endtask

    task automatic expect_beat(input string nm, input logic [15:0] v,
                               input logic pf);
        lit({nm, "_valid"}, 32'(out_valid), 32'd1);
        lit({nm, "_imm"}, 32'(imm_out), 32'(v));
        lit({nm, "_pf"}, 32'(imm_prefixed), 32'(pf));
    endtask

    initial begin
        #12;
        lit("rst_valid", 32'(out_valid), 32'd0);
        lit("rst_imm", 32'(imm_out), 32'd0);
        lit("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick;
        out_ready = 1'b1;

        drive(16'h0AB0, 3'b000); tick; expect_beat("m000", 16'h00AB, 0);
        drive(16'h0AB0, 3'b100); tick; expect_beat("m100", 16'hFFAB, 0);
        drive(16'h003E, 3'b001); tick; expect_beat("m001", 16'hFFFE, 0);
        drive(16'h0028, 3'b010); tick; expect_beat("m010", 16'h0005, 0);
        drive(16'h0AB0, 3'b111); tick; expect_beat("m111", 16'h0000, 0);

        drive(16'h0123, 3'b011); tick;
        lit("pfx_nobeat", 32'(out_valid), 32'd0);
        lit("np_pfx_valid", 32'(np_out_valid), 32'd1);
        lit("np_pfx_imm", 32'(np_imm), 32'd0);
        drive(16'h0450, 3'b000); tick; expect_beat("pfx_000", 16'h2345, 1);
        drive(16'h0450, 3'b000); tick; expect_beat("after_pfx", 16'h0045, 0);

        drive(16'h0FFF, 3'b011); tick;
        drive(16'h0001, 3'b011); tick;
        drive(16'h003F, 3'b001); tick; expect_beat("pfx_ovr", 16'h007F, 1);
        drive(16'h0123, 3'b011); tick;
        drive(16'h0028, 3'b010); tick; expect_beat("pfx_ign", 16'h0005, 0);
        drive(16'h0450, 3'b000); tick; expect_beat("pfx_used", 16'h0045, 0);

        out_ready = 1'b0;
        drive(16'h0AB0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            #1;
            lit("bp_ready", 32'(in_ready), 32'd0);
            expect_beat("bp_hold", 16'h0045, 0);
            tick;
        end
        out_ready = 1'b1;
        #1;
        lit("bp_release_ready", 32'(in_ready), 32'd1);
        tick; expect_beat("bp_next", 16'h00AB, 0);

        drive(16'h0123, 3'b011); tick;
        drive(16'h0450, 3'b000); flush = 1'b1; tick;
        flush = 1'b0;
        lit("flush_valid", 32'(out_valid), 32'd0);
        drive(16'h0450, 3'b000); tick; expect_beat("post_flush", 16'h0045, 0);

        out_ready = 1'b0;
        drive(16'h0AB0, 3'b100); tick;
        in_valid = 1'b0;
        lit("hold_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        lit("async_valid", 32'(out_valid), 32'd0);
        lit("async_imm", 32'(imm_out), 32'd0);
        lit("async_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick;

        for (int n = 0; n < 3000; n++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            instruction = 16'($urandom);
            ImmSrc      = ($urandom_range(0, 3) == 0) ? 3'b011
                                                      : 3'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        tick;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator sitting between fetch/decode and the ALU operand mux.
- Extracts and extends immediates from 16-bit instructions into a DATA_W-bit operand.
- Supports an IMM-prefix mode: a prefix instruction supplies the upper bits of the following instruction's immediate.
- One pipeline stage with a valid/ready handshake on both sides, plus a flush input for branch redirects.

Parameters:
- DATA_W, 16, output immediate width; legal range 8..32.
- PREFIX_EN, 1, when 0 mode 011 is treated as a reserved mode and no prefix state exists.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction/ImmSrc valid.
- in_ready  output  1  stage can accept an input this cycle.
- instruction  input  16  instruction word.
- ImmSrc  input  3  immediate mode select.
- flush  input  1  discard output register and pending prefix.
- out_valid  output  1  imm_out valid.
- out_ready  input  1  consumer accepts imm_out.
- imm_out  output  DATA_W  extended immediate.
- imm_prefixed  output  1  imm_out was built with a prefix.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, imm_out=0, imm_prefixed=0, prefix_pend=0, prefix_reg=0. in_ready=1 immediately after reset.
- in_ready = !out_valid || out_ready (combinational). An input is accepted when in_valid && in_ready.
- Latency: an accepted non-prefix input appears on imm_out, with out_valid=1, on the next rising edge.
- Output hold: while out_valid=1 && out_ready=0, imm_out and imm_prefixed hold. No input is accepted during the hold.
- When out_ready=1 and no new non-prefix input is accepted, out_valid clears on the next edge.
- Modes, unprefixed (sign-extend = replicate the top field bit up to DATA_W):
  - 000: zero-extend instruction[11:4].
  - 001: sign-extend instruction[5:0].
  - 010: zero-extend instruction[5:3] (shift amount).
  - 011: prefix.
  - 100: sign-extend instruction[11:4].
  - 101, 110, 111: imm_out=0.
- Prefix (011, PREFIX_EN=1):
  - An accepted prefix sets prefix_reg=instruction[11:0] and prefix_pend=1.
  - It produces no output beat: out_valid is not set by it, but an existing output beat still drains normally.
  - A second prefix while prefix_pend=1 overwrites prefix_reg.
- Prefixed modes (prefix_pend=1 at acceptance):
  - 000: zero-extend the 20-bit value {prefix_reg, instruction[11:4]}.
  - 100: sign-extend that value from bit 19.
  - 001: sign-extend the 18-bit value {prefix_reg, instruction[5:0]} from bit 17.
  - When DATA_W is smaller than the combined width, keep the low DATA_W bits.
  - imm_prefixed=1 for modes 000/001/100. For 010/101-111 the prefix is ignored and imm_prefixed=0.
- Any accepted non-prefix input clears prefix_pend on the same edge it is loaded.
- PREFIX_EN=0: mode 011 yields imm_out=0 with out_valid=1, and prefix_pend stays 0.
- Flush (synchronous, priority over everything):
  - On the edge where flush=1: out_valid=0, imm_prefixed=0, prefix_pend=0.
  - Any input accepted in that cycle is discarded.
  - in_ready follows its normal equation during flush.
- Reset mid-operation (rst_n low at any time): all state clears asynchronously, including a pending prefix and a held output.

Test Plan (DATA_W=16, PREFIX_EN=1 unless stated):
- Reset check: assert rst_n=0 mid-hold with out_valid=1 → out_valid=0, imm_out=0 and in_ready=1 with no clock edge.
- Unprefixed modes, one per cycle, out_ready=1:
  - 0x0AB0 mode 000 → 0x00AB.
  - 0x0AB0 mode 100 → 0xFFAB.
  - 0x003E mode 001 → 0xFFFE.
  - 0x0028 mode 010 → 0x0005.
  - 0x0AB0 mode 111 → 0x0000.
  - Each appears one cycle after acceptance.
- Prefix pair:
  - 0x0123 mode 011 → no out_valid.
  - Then 0x0450 mode 000 → 0x2345 with imm_prefixed=1.
  - A following 0x0450 mode 000 → 0x0045 with imm_prefixed=0.
- Prefix overwrite and ignore:
  - Prefix 0x0FFF, then prefix 0x0001, then 0x003F mode 001 → 0x007F (low 16 of sign-extended 0x007F).
  - Prefix then mode 010 on 0x0028 → 0x0005 with imm_prefixed=0, and the prefix is consumed.
- Backpressure:
  - out_valid=1, out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and imm_out stable.
  - Raise out_ready → the held beat drains and the next input is accepted the same cycle, then appears the following cycle.
- Flush:
  - Prefix 0x0123, then flush=1 together with in_valid (0x0450 mode 000) → input dropped, out_valid=0.
  - Next 0x0450 mode 000 → 0x0045, imm_prefixed=0.
  - With PREFIX_EN=0, mode 011 → imm_out=0, out_valid=1.
